// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and control width shared by the ALU bit slice,
// the n-bit ALU built from it, and the control unit that drives ctrl.
package alu_pkg;

    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] OP_ADD  = 3'b000;
    localparam logic [CTRL_W-1:0] OP_SUB  = 3'b001;
    localparam logic [CTRL_W-1:0] OP_OR   = 3'b010;
    localparam logic [CTRL_W-1:0] OP_ORN  = 3'b011;
    localparam logic [CTRL_W-1:0] OP_AND  = 3'b100;
    localparam logic [CTRL_W-1:0] OP_ANDN = 3'b101;
    localparam logic [CTRL_W-1:0] OP_NOTA = 3'b110;
    localparam logic [CTRL_W-1:0] OP_NOTB = 3'b111;

    // ADD and SUB are the only opcodes with ctrl[2:1] == 00.
    function automatic logic is_arith(input logic [CTRL_W-1:0] op);
        return (op[CTRL_W-1:1] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_full_adder.sv
// alu_full_adder: one-bit full adder used for the slice's ADD/SUB path.
// Ports: a, b, cin (in) -> s (sum), cout (carry), all combinational.
module alu_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one bit of the accumulator ALU with a registered result.
// Chain n slices with c_out of bit i feeding c_in of bit i+1.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in0, in1        operand A / B bit
//   ctrl[2:0]       opcode (see alu_pkg)
//   c_in            ripple carry in
//   in_valid        operands valid this cycle
//   c_out           combinational carry out (for rippling)
//   alu_out         registered result bit
//   c_out_q         registered copy of c_out
//   out_valid       registered result valid
//   g, p            (ALU_BITSLICE_GP_EN only) generate/propagate for an
//                   external carry-lookahead unit
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0,
    input  logic              in1,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              c_in,
    input  logic              in_valid,
    output logic              c_out,
    output logic              alu_out,
    output logic              c_out_q,
`ifdef ALU_BITSLICE_GP_EN
    output logic              g,
    output logic              p,
`endif
    output logic              out_valid
);

    logic b;
    logic sum;
    logic fa_cout;
    logic res;
    logic arith;

    // ctrl[0] inverts B for SUB and the inverted-B logic ops alike.
    assign b     = ctrl[0] ? ~in1 : in1;
    assign arith = is_arith(ctrl);

    alu_full_adder u_fa (
        .a    (in0),
        .b    (b),
        .cin  (c_in),
        .s    (sum),
        .cout (fa_cout)
    );

    always_comb begin
        res = 1'b0;
        case (ctrl)
            OP_ADD, OP_SUB:  res = sum;
            OP_OR,  OP_ORN:  res = in0 | b;
            OP_AND, OP_ANDN: res = in0 & b;
            OP_NOTA:         res = ~in0;
            OP_NOTB:         res = ~in1;
            default:         res = 1'b0;
        endcase
    end

    // Logic ops never produce a carry, whatever c_in is.
    assign c_out = arith & fa_cout;

`ifdef ALU_BITSLICE_GP_EN
    assign g = arith & (in0 & b);
    assign p = arith & (in0 ^ b);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out   <= 1'b0;
            c_out_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_out <= res;
                c_out_q <= c_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_bit_slice.sv
// tb_alu_bit_slice: scoreboard bench for alu_bit_slice. A single slice is
// exercised directly; a four-slice chain checks ripple and registered result.
module tb_alu_bit_slice;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic in0, in1, c_in, in_valid;
    logic [2:0] ctrl;
    logic c_out, alu_out, c_out_q, out_valid;
`ifdef ALU_BITSLICE_GP_EN
    logic g, p;
`endif

    always #5 clk = ~clk;

    alu_bit_slice dut (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .ctrl(ctrl),
        .c_in(c_in), .in_valid(in_valid), .c_out(c_out), .alu_out(alu_out),
        .c_out_q(c_out_q),
`ifdef ALU_BITSLICE_GP_EN
        .g(g), .p(p),
`endif
        .out_valid(out_valid)
    );

    // four-slice chain
    logic [3:0] ch_a, ch_b, ch_res, ch_cq, ch_ov;
    logic [4:0] ch_c;
    logic [2:0] ch_ctrl;
    logic       ch_valid;
`ifdef ALU_BITSLICE_GP_EN
    logic [3:0] ch_g, ch_p;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_chain
        alu_bit_slice u_s (
            .clk(clk), .rst_n(rst_n), .in0(ch_a[i]), .in1(ch_b[i]),
            .ctrl(ch_ctrl), .c_in(ch_c[i]), .in_valid(ch_valid),
            .c_out(ch_c[i+1]), .alu_out(ch_res[i]), .c_out_q(ch_cq[i]),
`ifdef ALU_BITSLICE_GP_EN
            .g(ch_g[i]), .p(ch_p[i]),
`endif
            .out_valid(ch_ov[i])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic [1:0] sb_q[$];   // {alu_out, c_out_q} expected per valid op
    logic hold_r = 1'b0, hold_c = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: arithmetic via integer add, logic ops from the opcode table.
    task automatic model(input logic [2:0] op, input logic a, input logic bb,
                         input logic ci, output logic r, output logic c);
        logic [1:0] s;
        logic bx;
        bx = op[0] ? !bb : bb;
        s = 2'(a) + 2'(bx) + 2'(ci);
        c = 1'b0;
        case (op)
            3'b000, 3'b001: begin r = s[0]; c = s[1]; end
            3'b010: r = a | bb;
            3'b011: r = a | !bb;
            3'b100: r = a & bb;
            3'b101: r = a & !bb;
            3'b110: r = !a;
            default: r = !bb;
        endcase
    endtask

    task automatic drive(input logic [2:0] op, input logic a, input logic bb,
                         input logic ci, input logic v);
        logic r, c, bx;
        logic [1:0] e;
        @(negedge clk);
        ctrl = op; in0 = a; in1 = bb; c_in = ci; in_valid = v;
        model(op, a, bb, ci, r, c);
        #1;
        chk("c_out", {7'd0, c_out}, {7'd0, c});
`ifdef ALU_BITSLICE_GP_EN
        bx = op[0] ? !bb : bb;
        chk("g", {7'd0, g}, {7'd0, (op[2:1] == 2'b00) & a & bx});
        chk("p", {7'd0, p}, {7'd0, (op[2:1] == 2'b00) & (a ^ bx)});
`else
        bx = 1'b0;
`endif
        if (v) sb_q.push_back({r, c});
        @(posedge clk); #1;
        chk("out_valid", {7'd0, out_valid}, {7'd0, v});
        if (v) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 8'd1, 8'd0);
            end else begin
                e = sb_q.pop_front();
                hold_r = e[1]; hold_c = e[0];
            end
        end
        chk("alu_out", {7'd0, alu_out}, {7'd0, hold_r});
        chk("c_out_q", {7'd0, c_out_q}, {7'd0, hold_c});
    endtask

    task automatic chain(input logic [2:0] op, input logic [3:0] a, input logic [3:0] bb,
                         input logic ci);
        logic [4:0] s;
        logic [3:0] bx;
        bx = op[0] ? ~bb : bb;
        s = 5'(a) + 5'(bx) + 5'(ci);
        @(negedge clk);
        ch_ctrl = op; ch_a = a; ch_b = bb; ch_c[0] = ci; ch_valid = 1'b1;
        #1;
        chk("chain_cout", {7'd0, ch_c[4]}, {7'd0, s[4]});
`ifdef ALU_BITSLICE_GP_EN
        chk("chain_g", {4'd0, ch_g}, {4'd0, a & bx});
        chk("chain_p", {4'd0, ch_p}, {4'd0, a ^ bx});
`endif
        @(posedge clk); #1;
        chk("chain_res", {4'd0, ch_res}, {4'd0, s[3:0]});
        chk("chain_cq", {7'd0, ch_cq[3]}, {7'd0, s[4]});
        chk("chain_ov", {4'd0, ch_ov}, 8'h0f);
        @(negedge clk); ch_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ctrl = OP_ADD; in0 = 0; in1 = 0; c_in = 0;
        ch_a = 0; ch_b = 0; ch_c[0] = 0; ch_ctrl = OP_ADD; ch_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // Load a 1 so the reset check below is meaningful.
        drive(OP_ADD, 1, 0, 0, 1);

        // Reset with valid all-ones ADD: outputs clear, c_out stays combinational.
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; ctrl = OP_ADD; in0 = 1; in1 = 1; c_in = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("rst_c_out", {7'd0, c_out}, 8'd1);
            @(posedge clk); #1;
            chk("rst_alu_out", {7'd0, alu_out}, 8'd0);
            chk("rst_c_out_q", {7'd0, c_out_q}, 8'd0);
            chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
            @(negedge clk);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        hold_r = 1'b0; hold_c = 1'b0;
        drive(OP_ADD, 1, 1, 1, 0);   // first cycle after reset: no stale valid

        // ADD exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(OP_ADD, v[2], v[1], v[0], 1);
        end

        // SUB directed
        drive(OP_SUB, 0, 1, 1, 1);
        drive(OP_SUB, 1, 0, 1, 1);

        // Logic ops with in0=1, in1=0, c_in=1
        for (int op = 2; op < 8; op++) drive(3'(op), 1, 0, 1, 1);

        // Hold: one valid, then invalid with changed inputs
        drive(OP_ADD, 1, 0, 0, 1);
        drive(OP_NOTA, 1, 1, 1, 0);
        drive(OP_AND, 0, 0, 0, 0);

        // Back-to-back alternating ops
        for (int i = 0; i < 6; i++) drive((i % 2) ? OP_NOTA : OP_ADD, 3'(i) == 3'd2, 1, 0, 1);

        // Random traffic
        for (int i = 0; i < 40; i++)
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

        // Chain
        chain(OP_SUB, 4'b0101, 4'b0011, 1'b1);
        chain(OP_ADD, 4'b1111, 4'b0001, 1'b0);
        chain(OP_ADD, 4'b0110, 4'b0011, 1'b1);
        chain(OP_SUB, 4'b0010, 4'b0101, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
